// File: rtl/enemy_ai_pkg.sv
// -----------------------------------------------------------------------------
// enemy_ai_pkg
// Shared types and constants for the enemy tank behaviour controller.
//   dir_t       : travel direction encoding (0=up, 1=right, 2=down, 3=left)
//   ai_state_t  : controller states
//   R_*         : bit positions of the fields taken from the 31-bit random word
//   map_slot()  : folds the 2-bit random slot value onto the three spawn columns
// -----------------------------------------------------------------------------
package enemy_ai_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_DEAD = 2'd0,
    S_WAIT = 2'd1,
    S_MOVE = 2'd2,
    S_TURN = 2'd3
  } ai_state_t;

  localparam int RAND_W = 31;
  localparam int POS_W  = 10;

  // Fields of rand_in; the spawn-delay and direction fields overlap the hold
  // field on purpose, they are consumed in different states.
  localparam int R_DIR_LSB   = 0;
  localparam int R_DIR_MSB   = 1;
  localparam int R_DLY_LSB   = 0;
  localparam int R_DLY_MSB   = 4;
  localparam int R_HOLD_LSB  = 2;
  localparam int R_HOLD_MSB  = 7;
  localparam int R_FIRE_LSB  = 9;
  localparam int R_FIRE_MSB  = 11;
  localparam int R_CHASE     = 12;
  localparam int R_SLOT_LSB  = 13;
  localparam int R_SLOT_MSB  = 14;

  // Only three spawn columns exist; value 3 is folded onto the middle one.
  function automatic logic [1:0] map_slot(input logic [1:0] raw);
    return (raw == 2'd3) ? 2'd1 : raw;
  endfunction

endpackage

// File: rtl/enemy_ai_ctrl_if.sv
// -----------------------------------------------------------------------------
// enemy_ai_ctrl_if
// Signal bundle between the game logic and one enemy_ai_ctrl instance.
//   master : game side, drives frame_tick, rand_in, spawn_req, kill, blocked,
//            self_x/self_y, player_x/player_y; observes the controller outputs
//   slave  : controller side, drives dir, move_en, fire, spawn, spawn_slot, alive
// -----------------------------------------------------------------------------
interface enemy_ai_ctrl_if;
  import enemy_ai_pkg::*;

  logic              frame_tick;
  logic [RAND_W-1:0] rand_in;
  logic              spawn_req;
  logic              kill;
  logic              blocked;
  logic [POS_W-1:0]  self_x;
  logic [POS_W-1:0]  self_y;
  logic [POS_W-1:0]  player_x;
  logic [POS_W-1:0]  player_y;
  logic [1:0]        dir;
  logic              move_en;
  logic              fire;
  logic              spawn;
  logic [1:0]        spawn_slot;
  logic              alive;

  modport master (
    output frame_tick, rand_in, spawn_req, kill, blocked,
           self_x, self_y, player_x, player_y,
    input  dir, move_en, fire, spawn, spawn_slot, alive
  );

  modport slave (
    input  frame_tick, rand_in, spawn_req, kill, blocked,
           self_x, self_y, player_x, player_y,
    output dir, move_en, fire, spawn, spawn_slot, alive
  );

endinterface

// File: rtl/ai_tick_counter.sv
// -----------------------------------------------------------------------------
// ai_tick_counter
// Loadable down-counter that only moves on tick and stops at zero.
//   clk, rst  : clock, synchronous active-high reset (clears the count)
//   load      : load load_val (wins over tick)
//   load_val  : value to load
//   tick      : decrement enable
//   cnt       : current count
//   zero      : cnt == 0
// -----------------------------------------------------------------------------
module ai_tick_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/enemy_ai_ctrl.sv
// -----------------------------------------------------------------------------
// enemy_ai_ctrl
// Behaviour controller for one enemy tank: spawn delay and column, travel
// direction, hold time per leg and shot requests, all driven by a free-running
// random word sampled on frame ticks.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : enemy_ai_ctrl_if.slave
//                in : frame_tick, rand_in[30:0], spawn_req, kill, blocked,
//                     self_x/y, player_x/y (positions only with chase enabled)
//                out: dir[1:0], move_en, fire, spawn, spawn_slot[1:0], alive
// Optional build macro ENEMY_AI_CHASE_EN: when defined, a turn with
// rand_in[12]=1 heads toward the player along the axis of larger distance.
// -----------------------------------------------------------------------------
module enemy_ai_ctrl
  import enemy_ai_pkg::*;
#(
  parameter int HOLD_BASE     = 16,
  parameter int SPAWN_BASE    = 32,
  parameter int FIRE_COOLDOWN = 30,
  parameter int FIRE_THRESH   = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  enemy_ai_ctrl_if.slave  bus
);

  localparam int CNT_W  = 7;
  localparam int COOL_W = $clog2(FIRE_COOLDOWN + 1);

  localparam logic [1:0] ST_DEAD = S_DEAD;
  localparam logic [1:0] ST_WAIT = S_WAIT;
  localparam logic [1:0] ST_MOVE = S_MOVE;
  localparam logic [1:0] ST_TURN = S_TURN;

  logic [1:0]        state, state_nx;
  logic              turn_forced, forced_nx;
  logic              alive_st;
  logic              wait_load, spawn_take, fire_take;
  logic              fire_ok, fire_hit;
  logic [CNT_W-1:0]  hold_cnt, wait_cnt, hold_load_val, wait_load_val;
  logic              hold_zero, wait_zero;
  logic [COOL_W-1:0] cool_cnt;
  logic              cool_zero;
  logic [1:0]        cand_dir, turn_dir;
  logic [1:0]        dir_q, slot_q;
  logic              move_q, fire_q, spawn_q, alive_q;

  assign alive_st      = (state == ST_MOVE) || (state == ST_TURN);
  assign hold_load_val = CNT_W'(HOLD_BASE)  + CNT_W'(bus.rand_in[R_HOLD_MSB:R_HOLD_LSB]);
  assign wait_load_val = CNT_W'(SPAWN_BASE) + CNT_W'(bus.rand_in[R_DLY_MSB:R_DLY_LSB]);

  // A shot is allowed on the tick that brings the cooldown to zero, so with
  // an eligible random field every tick the shots land FIRE_COOLDOWN ticks apart.
  assign fire_ok  = (cool_cnt <= COOL_W'(1));
  assign fire_hit = ({1'b0, bus.rand_in[R_FIRE_MSB:R_FIRE_LSB]} < 4'(FIRE_THRESH));

  always_comb begin
    state_nx   = state;
    forced_nx  = turn_forced;
    wait_load  = 1'b0;
    spawn_take = 1'b0;
    fire_take  = 1'b0;
    if (bus.kill) begin
      state_nx = ST_DEAD;
    end else begin
      case (state)
        ST_DEAD: begin
          if (bus.spawn_req) begin
            wait_load = 1'b1;
            state_nx  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.frame_tick && wait_zero) begin
            spawn_take = 1'b1;
            state_nx   = ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (bus.frame_tick) begin
            fire_take = fire_ok && fire_hit;
            if (bus.blocked) begin
              state_nx  = ST_TURN;
              forced_nx = 1'b1;
            end else if (hold_zero) begin
              state_nx  = ST_TURN;
              forced_nx = 1'b0;
            end
          end
        end
        ST_TURN: state_nx = ST_MOVE;
        default: state_nx = ST_DEAD;
      endcase
    end
  end

`ifdef ENEMY_AI_CHASE_EN
  logic signed [POS_W:0] dx, dy;
  logic        [POS_W:0] adx, ady;
  logic        [1:0]     chase_dir;

  // Screen y grows downward; ties (including zero distance) take the vertical axis.
  always_comb begin
    dx  = $signed({1'b0, bus.player_x}) - $signed({1'b0, bus.self_x});
    dy  = $signed({1'b0, bus.player_y}) - $signed({1'b0, bus.self_y});
    adx = (dx < 0) ? $unsigned(-dx) : $unsigned(dx);
    ady = (dy < 0) ? $unsigned(-dy) : $unsigned(dy);
    if (adx > ady) begin
      chase_dir = (dx < 0) ? DIR_LEFT : DIR_RIGHT;
    end else begin
      chase_dir = (dy < 0) ? DIR_UP : DIR_DOWN;
    end
  end
`endif

  always_comb begin
    cand_dir = bus.rand_in[R_DIR_MSB:R_DIR_LSB];
`ifdef ENEMY_AI_CHASE_EN
    if (bus.rand_in[R_CHASE]) begin
      cand_dir = chase_dir;
    end
`endif
    // A forced turn must leave the blocked direction.
    turn_dir = (turn_forced && (cand_dir == dir_q)) ? cand_dir + 2'd1 : cand_dir;
  end

  // Random bits this controller never reads, plus positions in the default build.
  logic unused_bits;
  assign unused_bits = ^{bus.rand_in[RAND_W-1:R_SLOT_MSB+1], bus.rand_in[R_CHASE],
                         bus.rand_in[R_FIRE_LSB-1], bus.self_x, bus.self_y,
                         bus.player_x, bus.player_y, wait_cnt, hold_cnt, cool_zero};

  ai_tick_counter #(.W(CNT_W)) u_wait (
    .clk      (Clk),
    .rst      (Reset),
    .load     (wait_load),
    .load_val (wait_load_val),
    .tick     (bus.frame_tick && (state == ST_WAIT)),
    .cnt      (wait_cnt),
    .zero     (wait_zero)
  );

  ai_tick_counter #(.W(CNT_W)) u_hold (
    .clk      (Clk),
    .rst      (Reset),
    .load     (spawn_take || (state == ST_TURN)),
    .load_val (hold_load_val),
    .tick     (bus.frame_tick && (state == ST_MOVE) && !bus.blocked),
    .cnt      (hold_cnt),
    .zero     (hold_zero)
  );

  ai_tick_counter #(.W(COOL_W)) u_cool (
    .clk      (Clk),
    .rst      (Reset),
    .load     (spawn_take || fire_take),
    .load_val (COOL_W'(FIRE_COOLDOWN)),
    .tick     (bus.frame_tick && alive_st),
    .cnt      (cool_cnt),
    .zero     (cool_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_DEAD;
      turn_forced <= 1'b0;
      dir_q       <= DIR_DOWN;
      slot_q      <= 2'd0;
      move_q      <= 1'b0;
      fire_q      <= 1'b0;
      spawn_q     <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state       <= state_nx;
      turn_forced <= forced_nx;
      move_q      <= (state_nx == ST_MOVE);
      alive_q     <= (state_nx == ST_MOVE) || (state_nx == ST_TURN);
      fire_q      <= fire_take;
      spawn_q     <= spawn_take;
      if (spawn_take) begin
        dir_q  <= DIR_DOWN;
        slot_q <= map_slot(bus.rand_in[R_SLOT_MSB:R_SLOT_LSB]);
      end else if ((state == ST_TURN) && !bus.kill) begin
        dir_q <= turn_dir;
      end
    end
  end

  assign bus.dir        = dir_q;
  assign bus.move_en    = move_q;
  assign bus.fire       = fire_q;
  assign bus.spawn      = spawn_q;
  assign bus.spawn_slot = slot_q;
  assign bus.alive      = alive_q;

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enemy_ai_ctrl
// Self-checking bench for enemy_ai_ctrl: directed scenarios with hand-derived
// expectations followed by randomized traffic, all outputs compared every
// cycle against a tick-counting behavioural model.
// -----------------------------------------------------------------------------
module tb_enemy_ai_ctrl;
  import enemy_ai_pkg::*;

  localparam int HB = 16;
  localparam int SB = 32;
  localparam int FC = 30;
  localparam int FT = 2;

  localparam int MD_DEAD = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_MOVE = 2;
  localparam int MD_TURN = 3;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst = 1'b1;
  logic        tick = 1'b0, sreq = 1'b0, kl = 1'b0, blk = 1'b0;
  logic [30:0] r = '0;
  logic        Reset;

  enemy_ai_ctrl_if bus();

  assign Reset          = rst;
  assign bus.frame_tick = tick;
  assign bus.rand_in    = r;
  assign bus.spawn_req  = sreq;
  assign bus.kill       = kl;
  assign bus.blocked    = blk;
  assign bus.self_x     = 10'd100;
  assign bus.self_y     = 10'd200;
  assign bus.player_x   = 10'd300;
  assign bus.player_y   = 10'd50;

  enemy_ai_ctrl #(
    .HOLD_BASE(HB), .SPAWN_BASE(SB), .FIRE_COOLDOWN(FC), .FIRE_THRESH(FT)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int ncheck = 0;
  int npass  = 0;
  bit chk_en = 1'b0;

  // Model: counts ticks up toward the targets the rules define.
  int m_mode = MD_DEAD;
  int m_delay, m_waited, m_leg_len, m_leg_done, m_since;
  bit m_forced;
  int e_dir = 2, e_move = 0, e_fire = 0, e_spawn = 0, e_slot = 0, e_alive = 0;

  task automatic chk(input string nm, input int act, input int exp);
    ncheck++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int nd;
    if (rst) begin
      m_mode = MD_DEAD;
      e_dir = 2; e_move = 0; e_fire = 0; e_spawn = 0; e_slot = 0; e_alive = 0;
    end else begin
      e_fire  = 0;
      e_spawn = 0;
      if (kl) begin
        m_mode = MD_DEAD;
      end else begin
        case (m_mode)
          MD_DEAD: if (sreq) begin
            m_delay = SB + int'(r[4:0]); m_waited = 0; m_mode = MD_WAIT;
          end
          MD_WAIT: if (tick) begin
            if (m_waited == m_delay) begin
              e_spawn = 1;
              e_slot  = (r[14:13] == 2'd3) ? 1 : int'(r[14:13]);
              e_dir   = 2;
              m_leg_len = HB + int'(r[7:2]); m_leg_done = 0;
              m_since = 0;
              m_mode  = MD_MOVE;
            end else begin
              m_waited++;
            end
          end
          MD_MOVE: if (tick) begin
            m_since++;
            if (m_since >= FC && int'(r[11:9]) < FT) begin
              e_fire = 1; m_since = 0;
            end
            if (blk) begin
              m_forced = 1; m_mode = MD_TURN;
            end else if (m_leg_done == m_leg_len) begin
              m_forced = 0; m_mode = MD_TURN;
            end else begin
              m_leg_done++;
            end
          end
          default: begin
            if (tick) m_since++;
            nd = int'(r[1:0]);
            if (m_forced && nd == e_dir) nd = (nd + 1) % 4;
            e_dir = nd;
            m_leg_len = HB + int'(r[7:2]); m_leg_done = 0;
            m_mode = MD_MOVE;
          end
        endcase
      end
      e_move  = (m_mode == MD_MOVE) ? 1 : 0;
      e_alive = (m_mode == MD_MOVE || m_mode == MD_TURN) ? 1 : 0;
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("dir",        int'(bus.dir),        e_dir);
      chk("move_en",    int'(bus.move_en),    e_move);
      chk("fire",       int'(bus.fire),       e_fire);
      chk("spawn",      int'(bus.spawn),      e_spawn);
      chk("spawn_slot", int'(bus.spawn_slot), e_slot);
      chk("alive",      int'(bus.alive),      e_alive);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    model_step();
    #2;
  endtask

  // One frame tick followed by two quiet cycles; returns outputs seen right after the tick.
  task automatic do_tick(output logic sp, output logic fi, output logic mv);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    sp = bus.spawn; fi = bus.fire; mv = bus.move_en;
    cyc();
    cyc();
  endtask

  initial begin
    logic sp, fi, mv;
    int   n, nfire, nspawn, nalive;
    int   fire_at[$];

    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_dir", int'(bus.dir), 2);
    chk("rst_alive", int'(bus.alive), 0);
    cyc();

    // Spawn: delay field 3, slot field 3, hold field 0, no fire, dir field 3.
    r = 31'h6A03;
    sreq = 1'b1; cyc(); sreq = 1'b0;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      do_tick(sp, fi, mv);
      if (sp) begin n = i; break; end
    end
    chk("spawn_tick", n, 36);
    chk("spawn_slot_lit", int'(bus.spawn_slot), 1);
    chk("spawn_dir_lit", int'(bus.dir), 2);
    chk("spawn_move_lit", int'(bus.move_en), 1);

    // Unforced turn after HOLD_BASE+1 ticks.
    n = -1; nfire = 0;
    for (int i = 1; i <= 40; i++) begin
      do_tick(sp, fi, mv);
      if (fi) nfire++;
      if (!mv) begin n = i; break; end
    end
    chk("turn_tick", n, 17);
    chk("turn_dir_lit", int'(bus.dir), 3);
    chk("turn_move_back", int'(bus.move_en), 1);
    chk("no_fire_thr5", nfire, 0);

    // Forced turns with dir field 1: 3 -> 1, then 1 -> 2.
    r = 31'h6A01; blk = 1'b1;
    do_tick(sp, fi, mv);
    chk("forced_dir_a", int'(bus.dir), 1);
    do_tick(sp, fi, mv);
    chk("forced_dir_b", int'(bus.dir), 2);
    blk = 1'b0;

    // Fire spacing with fire field 0 every tick.
    r = 31'h6003;
    for (int i = 1; i <= 100; i++) begin
      do_tick(sp, fi, mv);
      if (fi) fire_at.push_back(i);
    end
    chk("fire_count", (fire_at.size() >= 3) ? 1 : 0, 1);
    if (fire_at.size() >= 3) begin
      chk("fire_first", fire_at[0], 11);
      chk("fire_gap1", fire_at[1] - fire_at[0], 30);
      chk("fire_gap2", fire_at[2] - fire_at[1], 30);
    end
    r = 31'h6A03; nfire = 0;
    for (int i = 1; i <= 70; i++) begin
      do_tick(sp, fi, mv);
      if (fi) nfire++;
    end
    chk("no_fire_thr5b", nfire, 0);

    // kill and spawn_req together.
    kl = 1'b1; sreq = 1'b1; cyc(); kl = 1'b0; sreq = 1'b0;
    chk("kill_alive", int'(bus.alive), 0);
    chk("kill_move", int'(bus.move_en), 0);
    nspawn = 0; nalive = 0;
    for (int i = 1; i <= 70; i++) begin
      do_tick(sp, fi, mv);
      if (sp) nspawn++;
      if (bus.alive) nalive++;
    end
    chk("kill_no_spawn", nspawn, 0);
    chk("kill_stays_dead", nalive, 0);

    // Respawn, turn to right, then reset mid-move on a fire-eligible tick.
    r = 31'h6A00;
    sreq = 1'b1; cyc(); sreq = 1'b0;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      do_tick(sp, fi, mv);
      if (sp) begin n = i; break; end
    end
    chk("spawn_tick2", n, 33);
    r = 31'h6001; blk = 1'b1;
    do_tick(sp, fi, mv);
    blk = 1'b0;
    chk("pre_rst_dir", int'(bus.dir), 1);
    r = 31'h6000; tick = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0; tick = 1'b0;
    chk("mid_rst_dir", int'(bus.dir), 2);
    chk("mid_rst_move", int'(bus.move_en), 0);
    chk("mid_rst_alive", int'(bus.alive), 0);
    chk("mid_rst_fire", int'(bus.fire), 0);

    // Randomized traffic.
    for (int i = 0; i < 20000; i++) begin
      r    = 31'($urandom);
      tick = ($urandom_range(0, 2) == 0);
      sreq = ($urandom_range(0, 15) == 0);
      kl   = ($urandom_range(0, 299) == 0);
      blk  = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 1999) == 0);
      cyc();
    end
    tick = 1'b0; sreq = 1'b0; kl = 1'b0; blk = 1'b0; rst = 1'b0;
    cyc();
    @(negedge Clk);
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
